// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: shared types and default widths for the framebuffer port arbiter.
// Contents: FSM state enum, transaction owner enum, AW/DW word address/data widths.
package fb_arb_pkg;
    localparam int AW = 14;
    localparam int DW = 16;
    typedef enum logic [1:0] {IDLE, REQ, RWAIT, DONE} state_t;
    typedef enum logic {OWN_DISP, OWN_DRAW} owner_t;
endpackage

// File: rtl/fb_port_arbiter_if.sv
// fb_port_arbiter_if: signal bundle around the framebuffer port arbiter.
// Groups: display address/data FIFO ports, draw req/ack port, memory port.
// slave = arbiter view, master = environment view (FIFOs, draw engine, memory).
interface fb_port_arbiter_if;
    import fb_arb_pkg::*;
    logic          disp_addr_empty;
    logic [AW-1:0] disp_addr_rd;
    logic          disp_addr_ren;
    logic          disp_data_wen;
    logic [DW-1:0] disp_data_wd;
    logic          disp_data_full;
    logic          drw_req;
    logic          drw_we;
    logic [AW-1:0] drw_addr;
    logic [DW-1:0] drw_wd;
    logic [DW-1:0] drw_mask;
    logic          drw_ack;
    logic [DW-1:0] drw_rd;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_wmask;
    logic          mem_ack;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rd;
    modport slave (
        input  disp_addr_empty, disp_addr_rd, disp_data_full,
        input  drw_req, drw_we, drw_addr, drw_wd, drw_mask,
        input  mem_ack, mem_rvalid, mem_rd,
        output disp_addr_ren, disp_data_wen, disp_data_wd,
        output drw_ack, drw_rd,
        output mem_req, mem_we, mem_addr, mem_wd, mem_wmask
    );
    modport master (
        output disp_addr_empty, disp_addr_rd, disp_data_full,
        output drw_req, drw_we, drw_addr, drw_wd, drw_mask,
        output mem_ack, mem_rvalid, mem_rd,
        input  disp_addr_ren, disp_data_wen, disp_data_wd,
        input  drw_ack, drw_rd,
        input  mem_req, mem_we, mem_addr, mem_wd, mem_wmask
    );
endinterface

// File: rtl/fb_arb_stats.sv
// fb_arb_stats: wrapping 16-bit grant and draw-stall counters for the arbiter.
// Ports: clk, rst (sync, active-high), disp_grant/draw_grant/stall event strobes,
// disp_cnt/draw_cnt/stall_cnt counter outputs.
module fb_arb_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        disp_grant,
    input  logic        draw_grant,
    input  logic        stall,
    output logic [15:0] disp_cnt,
    output logic [15:0] draw_cnt,
    output logic [15:0] stall_cnt
);
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_cnt  <= '0;
            draw_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            disp_cnt  <= disp_cnt + 16'(disp_grant);
            draw_cnt  <= draw_cnt + 16'(draw_grant);
            stall_cnt <= stall_cnt + 16'(stall);
        end
    end
endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one framebuffer memory port between display (priority) and draw engine.
// Ports: clk, rst (sync, active-high), bus (fb_port_arbiter_if.slave).
// Optional FB_ARB_STATS_EN adds stat_disp_cnt, stat_draw_cnt, stat_stall_cnt outputs.
module fb_port_arbiter
    import fb_arb_pkg::*;
#(
    parameter int MAX_DISP_STREAK = 4
) (
    input  logic             clk,
    input  logic             rst,
    fb_port_arbiter_if.slave bus
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]      stat_disp_cnt,
    output logic [15:0]      stat_draw_cnt,
    output logic [15:0]      stat_stall_cnt
`endif
);
    localparam int SW = $clog2(MAX_DISP_STREAK + 1);
    localparam logic [SW-1:0] SMAX = SW'(MAX_DISP_STREAK);
    state_t        state, state_nxt;
    owner_t        owner;
    logic [SW-1:0] streak;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wd, lat_mask, rdata;
    logic          disp_ok, grant_draw, grant_disp, capture, done_disp, done_draw;
    assign disp_ok = ~bus.disp_addr_empty & ~bus.disp_data_full;
    // grants are suppressed while rst is high so no FIFO entry is popped and then lost
    assign grant_draw = ~rst & (state == IDLE) & bus.drw_req & (~disp_ok | (streak == SMAX));
    assign grant_disp = ~rst & (state == IDLE) & disp_ok & ~grant_draw;
    assign capture = bus.mem_rvalid & (((state == REQ) & bus.mem_ack & ~lat_we) | (state == RWAIT));
    assign done_disp = (state == DONE) & (owner == OWN_DISP);
    assign done_draw = (state == DONE) & (owner == OWN_DRAW);
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nxt;
    end
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = (grant_draw | grant_disp) ? REQ : IDLE;
            REQ:     state_nxt = ~bus.mem_ack ? REQ : (lat_we | bus.mem_rvalid) ? DONE : RWAIT;
            RWAIT:   state_nxt = bus.mem_rvalid ? DONE : RWAIT;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            owner    <= OWN_DISP;
            streak   <= '0;
            lat_we   <= 1'b0;
            lat_addr <= '0;
            lat_wd   <= '0;
            lat_mask <= '0;
            rdata    <= '0;
        end else begin
            if (grant_draw) begin
                owner    <= OWN_DRAW;
                streak   <= '0;
                lat_we   <= bus.drw_we;
                lat_addr <= bus.drw_addr;
                lat_wd   <= bus.drw_we ? bus.drw_wd : '0;
                lat_mask <= bus.drw_we ? bus.drw_mask : '0;
            end else if (grant_disp) begin
                owner    <= OWN_DISP;
                streak   <= (streak == SMAX) ? SMAX : streak + 1'b1;
                lat_we   <= 1'b0;
                lat_addr <= bus.disp_addr_rd;
                lat_wd   <= '0;
                lat_mask <= '0;
            end
            if (capture) rdata <= bus.mem_rd;
        end
    end
    always_comb begin
        bus.disp_addr_ren = grant_disp;
        bus.mem_req       = (state == REQ);
        bus.mem_we        = (state == REQ) & lat_we;
        bus.mem_addr      = (state == REQ) ? lat_addr : '0;
        bus.mem_wd        = (state == REQ) ? lat_wd : '0;
        bus.mem_wmask     = (state == REQ) ? lat_mask : '0;
        bus.disp_data_wen = done_disp;
        bus.disp_data_wd  = done_disp ? rdata : '0;
        bus.drw_ack       = done_draw;
        bus.drw_rd        = (done_draw & ~lat_we) ? rdata : '0;
    end
`ifdef FB_ARB_STATS_EN
    logic stall;
    // draw is stalled whenever it is not the owner of an active transaction
    assign stall = bus.drw_req & ~((state != IDLE) & (owner == OWN_DRAW));
    fb_arb_stats u_stats (
        .clk        (clk),
        .rst        (rst),
        .disp_grant (grant_disp),
        .draw_grant (grant_draw),
        .stall      (stall),
        .disp_cnt   (stat_disp_cnt),
        .draw_cnt   (stat_draw_cnt),
        .stall_cnt  (stat_stall_cnt)
    );
`endif
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: table-driven directed bench for fb_port_arbiter plus multi-cycle corner sequences.
module tb_fb_port_arbiter;
    import fb_arb_pkg::*;
    typedef struct packed {
        logic          rst, empty, full;
        logic [AW-1:0] daddr;
        logic          req, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd, mask;
        logic          ack, rv;
        logic [DW-1:0] rd;
    } in_t;
    typedef struct packed {
        logic          ren, dwen;
        logic [DW-1:0] dwd;
        logic          dack;
        logic [DW-1:0] drd;
        logic          mreq, mwe;
        logic [AW-1:0] maddr;
        logic [DW-1:0] mwd, mmask;
    } out_t;
    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;
    logic clk = 1'b0;
    logic rst;
    int   ncmp = 0;
    int   nfail = 0;
    vec_t tbl[$];
    always #5 clk = ~clk;
    fb_port_arbiter_if bus ();
`ifdef FB_ARB_STATS_EN
    logic [15:0] s_disp, s_draw, s_stall;
    fb_port_arbiter #(.MAX_DISP_STREAK(4)) dut (.clk(clk), .rst(rst), .bus(bus),
        .stat_disp_cnt(s_disp), .stat_draw_cnt(s_draw), .stat_stall_cnt(s_stall));
`else
    fb_port_arbiter #(.MAX_DISP_STREAK(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif
    task automatic drive(input in_t v);
        rst                 = v.rst;
        bus.disp_addr_empty = v.empty;
        bus.disp_data_full  = v.full;
        bus.disp_addr_rd    = v.daddr;
        bus.drw_req         = v.req;
        bus.drw_we          = v.we;
        bus.drw_addr        = v.addr;
        bus.drw_wd          = v.wd;
        bus.drw_mask        = v.mask;
        bus.mem_ack         = v.ack;
        bus.mem_rvalid      = v.rv;
        bus.mem_rd          = v.rd;
    endtask
    function automatic out_t smp();
        return '{bus.disp_addr_ren, bus.disp_data_wen, bus.disp_data_wd, bus.drw_ack, bus.drw_rd,
                 bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wd, bus.mem_wmask};
    endfunction
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask
    in_t  idle;
    in_t  cur;
    logic [9:0] ord;
    int   got, cnt;
    initial begin
        idle = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        // display reads 0x40..0x42: ack at once, rvalid two cycles later
        tbl.push_back('{'{0,0,0,'h40,0,0,0,0,0,0,0,0},      '{1,0,0,0,0,0,0,0,0,0}});
        tbl.push_back('{'{0,0,0,'h41,0,0,0,0,0,1,0,0},      '{0,0,0,0,0,1,0,'h40,0,0}});
        tbl.push_back('{'{0,0,0,'h41,0,0,0,0,0,0,0,0},      '{0,0,0,0,0,0,0,0,0,0}});
        tbl.push_back('{'{0,0,0,'h41,0,0,0,0,0,0,1,'h1111}, '{0,0,0,0,0,0,0,0,0,0}});
        tbl.push_back('{'{0,0,0,'h41,0,0,0,0,0,0,0,0},      '{0,1,'h1111,0,0,0,0,0,0,0}});
        tbl.push_back('{'{0,0,0,'h41,0,0,0,0,0,0,0,0},      '{1,0,0,0,0,0,0,0,0,0}});
        tbl.push_back('{'{0,0,0,'h42,0,0,0,0,0,1,0,0},      '{0,0,0,0,0,1,0,'h41,0,0}});
        tbl.push_back('{'{0,0,0,'h42,0,0,0,0,0,0,0,0},      '{0,0,0,0,0,0,0,0,0,0}});
        tbl.push_back('{'{0,0,0,'h42,0,0,0,0,0,0,1,'h2222}, '{0,0,0,0,0,0,0,0,0,0}});
        tbl.push_back('{'{0,0,0,'h42,0,0,0,0,0,0,0,0},      '{0,1,'h2222,0,0,0,0,0,0,0}});
        tbl.push_back('{'{0,0,0,'h42,0,0,0,0,0,0,0,0},      '{1,0,0,0,0,0,0,0,0,0}});
        tbl.push_back('{'{0,1,0,0,0,0,0,0,0,1,0,0},         '{0,0,0,0,0,1,0,'h42,0,0}});
        tbl.push_back('{'{0,1,0,0,0,0,0,0,0,0,0,0},         '{0,0,0,0,0,0,0,0,0,0}});
        tbl.push_back('{'{0,1,0,0,0,0,0,0,0,0,1,'h3333},    '{0,0,0,0,0,0,0,0,0,0}});
        tbl.push_back('{'{0,1,0,0,0,0,0,0,0,0,0,0},         '{0,1,'h3333,0,0,0,0,0,0,0}});
        tbl.push_back('{'{0,1,0,0,0,0,0,0,0,0,0,0},         '{0,0,0,0,0,0,0,0,0,0}});
        // draw write at the top address, completes without rvalid
        tbl.push_back('{'{0,1,0,0,1,1,'h3FFF,'hA5A5,'h00FF,0,0,0}, '{0,0,0,0,0,0,0,0,0,0}});
        tbl.push_back('{'{0,1,0,0,1,1,'h3FFF,'hA5A5,'h00FF,1,0,0}, '{0,0,0,0,0,1,1,'h3FFF,'hA5A5,'h00FF}});
        tbl.push_back('{'{0,1,0,0,1,1,'h3FFF,'hA5A5,'h00FF,0,0,0}, '{0,0,0,1,0,0,0,0,0,0}});
        tbl.push_back('{'{0,1,0,0,0,0,0,0,0,0,0,0},                '{0,0,0,0,0,0,0,0,0,0}});
        // data FIFO full: pending display address must not be popped, draw read served
        tbl.push_back('{'{0,0,1,'h50,1,0,'h0123,0,'hFFFF,0,0,0},       '{0,0,0,0,0,0,0,0,0,0}});
        tbl.push_back('{'{0,0,1,'h50,1,0,'h0123,0,'hFFFF,1,1,'hBEEF},  '{0,0,0,0,0,1,0,'h0123,0,0}});
        tbl.push_back('{'{0,0,1,'h50,1,0,'h0123,0,'hFFFF,0,0,0},       '{0,0,0,1,'hBEEF,0,0,0,0,0}});
        tbl.push_back('{'{0,0,1,'h50,0,0,0,0,0,0,0,0},                 '{0,0,0,0,0,0,0,0,0,0}});
        cur = idle;
        cur.rst = 1'b1;
        drive(cur);
        repeat (2) @(posedge clk);
        #1;
        drive(idle);
        #1;
        chk("reset_outputs", 128'(smp()), 128'(0));
        next_cycle();
        for (int n = 0; n < tbl.size(); n++) begin
            drive(tbl[n].i);
            #1;
            chk($sformatf("row%0d", n), 128'(smp()), 128'(tbl[n].o));
            next_cycle();
        end
        // both requesters always pending, memory completes in one cycle
        cur = '{0, 0, 0, 'h10, 1, 0, 'h20, 0, 0, 1, 1, 'h5555};
        drive(cur);
        got = 0;
        ord = '0;
        for (int c = 0; c < 80 && got < 10; c++) begin
            #1;
            if (bus.disp_data_wen || bus.drw_ack) begin
                ord[got] = bus.drw_ack;
                got++;
            end
            next_cycle();
        end
        drive(idle);
        chk("order_count", 128'(got), 128'(10));
        for (int k = 0; k < 10; k++)
            chk($sformatf("order%0d", k), 128'(ord[k]), 128'((k == 4) || (k == 9)));
        next_cycle();
        // memory holds off mem_ack for five cycles
        cur = '{0, 1, 0, 0, 1, 1, 'h1234, 'h5A5A, 'hF0F0, 0, 0, 0};
        drive(cur);
        next_cycle();
        for (int k = 0; k < 6; k++) begin
            cur.ack = (k == 5);
            drive(cur);
            #1;
            chk($sformatf("stall_hold%0d", k), 128'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wd, bus.mem_wmask}),
                128'({1'b1, 1'b1, 14'h1234, 16'h5A5A, 16'hF0F0}));
            next_cycle();
        end
        cur.ack = 1'b0;
        drive(cur);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (bus.drw_ack) cnt++;
            next_cycle();
            if (cnt != 0) drive(idle);
        end
        chk("delayed_ack_pulses", 128'(cnt), 128'(1));
        // reset while waiting for read data; the late rvalid must be dropped
        cur = '{0, 0, 0, 'h77, 0, 0, 0, 0, 0, 0, 0, 0};
        drive(cur);
        next_cycle();
        cur = idle;
        cur.ack = 1'b1;
        drive(cur);
        #1;
        chk("rst_req_addr", 128'({bus.mem_req, bus.mem_addr}), 128'({1'b1, 14'h77}));
        next_cycle();
        drive(idle);
        next_cycle();
        cur = idle;
        cur.rst = 1'b1;
        drive(cur);
        next_cycle();
        cur = idle;
        cur.rv = 1'b1;
        cur.rd = 'hDEAD;
        drive(cur);
        #1;
        chk("post_rst_outputs", 128'(smp()), 128'(0));
        next_cycle();
        drive(idle);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (bus.drw_ack || bus.disp_data_wen || bus.mem_req) cnt++;
            next_cycle();
        end
        chk("post_rst_quiet", 128'(cnt), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
